spike_out_queue: RTL
====================

Name: spike_out_queue

Overview:
- Sits directly downstream of the neuron core, between its output spike strobe/AER word and the NoC router injection port.
- Captures every fired-neuron AER packet into a FIFO and presents it to the router with a valid/ready handshake.
- Drops packets on overflow and counts them, so that back-pressure never stalls the neuron pipeline.
- Reports drain status so the time-step scheduler can hold off the next start pulse.

Parameters:
- AER_BIT_WIDTH, 32, width of the spike packet.
- FIFO_DEPTH, 4, number of packet entries; must be a power of 2, ≥2.
- PTR_BIT_WIDTH, 2, log2(FIFO_DEPTH).
- DROP_CNT_BIT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock; all logic rises on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- outSpike_i  in  1  spike strobe from the neuron core; each high cycle is one packet.
- SpikeAER_i  in  AER_BIT_WIDTH  packet word; sampled in the same cycle as outSpike_i.
- start_i  in  1  time-step start pulse, shared with the neuron controller.
- clrStat_i  in  1  synchronous clear of the drop counter and overflow flag.
- pktValid_o  out  1  head packet valid toward the router.
- pktData_o  out  AER_BIT_WIDTH  head packet, first-word-fall-through.
- pktReady_i  in  1  router accepts the head packet when pktValid_o and pktReady_i are both high.
- drained_o  out  1  FIFO empty and no push in the current cycle.
- stepOvf_o  out  1  sticky flag: a drop occurred since the last clear.
- dropCnt_o  out  DROP_CNT_BIT_WIDTH  saturating count of dropped packets.
- late_o  out  1  one-cycle pulse: start_i arrived while the FIFO was non-empty.

Behaviour:
- Reset, asynchronous on rst_i high:
  - pointers = 0, count = 0, pktValid_o = 0, pktData_o = 0.
  - drained_o = 1, stepOvf_o = 0, dropCnt_o = 0, late_o = 0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all queued packets; no packet is emitted after reset deasserts until a new push.
- Storage: circular buffer with write pointer wp and read pointer rp (PTR_BIT_WIDTH bits, natural wrap) and count (PTR_BIT_WIDTH+1 bits).
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Push request: outSpike_i = 1.
  - Accepted if !full, or if full and a pop occurs in the same cycle.
  - On accept: mem[wp] <= SpikeAER_i, wp++.
- Pop: pktValid_o & pktReady_i; rp++.
  - Push and pop in the same cycle leave count unchanged.
  - Simultaneous push and pop when empty is impossible, because pktValid_o = 0 when empty.
- Output is first-word-fall-through:
  - pktValid_o = !empty (combinational from count register).
  - pktData_o = mem[rp] when valid, else 0.
- Latency: a packet pushed in cycle N is visible on pktValid_o/pktData_o in cycle N+1 if the queue was empty.
- Ordering: strict FIFO order; a packet is never duplicated.
- Once asserted, pktValid_o stays high and pktData_o stays stable until accepted. This is the router protocol requirement.
- Overflow (push requested, full, no pop):
  - The packet is dropped and the FIFO is unchanged.
  - dropCnt_o increments, saturating at all-ones.
  - stepOvf_o <= 1.
- clrStat_i: dropCnt_o <= 0 and stepOvf_o <= 0. If a drop happens in the same cycle, clear wins for the counter, then the counter counts 1, and stepOvf_o = 1.
- drained_o = empty & !outSpike_i (combinational).
- late_o: registered, pulses 1 cycle after start_i if count != 0 at the start_i edge. Queued packets are still delivered; nothing is flushed.
- Control state machine, two states:
  - IDLE (empty) → ACTIVE on accepted push.
  - ACTIVE → IDLE when count reaches 0 after a pop with no push.
  - pktValid_o = (state == ACTIVE).
  - State must agree with count; the bench checks this with an assertion.

Decomposition:
- Shared package holds:
  - the AER_BIT_WIDTH default;
  - the state encoding constants S_IDLE and S_ACTIVE;
  - a packet-field split helper (dest/neuron-id slices) for future routing use.
- One natural sub-module, spike_fifo_mem: the DEPTH×AER_BIT_WIDTH register file with one write and one async read port. Pointer, count, flag and FSM logic stay in the parent.

Test Plan:
- Reset, then push AER 0xA5A5_0001 with pktReady_i = 1 → pktValid_o = 1 in the next cycle with pktData_o = 0xA5A5_0001, popped the same cycle; drained_o = 1 afterwards; dropCnt_o = 0.
- Hold pktReady_i = 0 and push 6 packets 0x1..0x6 back-to-back (DEPTH 4) → packets 0x5 and 0x6 dropped; dropCnt_o = 2; stepOvf_o = 1. Then raise ready → output sequence 0x1, 0x2, 0x3, 0x4; pktData_o stable while stalled.
- Full FIFO, push 0x7 with a simultaneous pop → accepted, count stays 4, no drop. Drain order is 0x2, 0x3, 0x4, 0x7.
- 300 overflow pushes, then clrStat_i → dropCnt_o saturates at 255; after clear dropCnt_o = 0 and stepOvf_o = 0.
- start_i pulsed with 2 packets queued → late_o = 1 for exactly 1 cycle; both packets still delivered; start_i with the queue empty → late_o stays 0.
- Assert rst_i mid-drain with 3 queued → pktValid_o drops to 0 asynchronously; no stale packet appears after release; wrap-around verified across 10 fill/drain cycles.

Source files
------------

// File: rtl/spike_out_queue_pkg.sv
// Shared definitions for the spike output queue.
//   DEFAULT_AER_BIT_WIDTH : default width of one AER spike packet
//   S_IDLE / S_ACTIVE     : control state encoding (IDLE = queue empty)
//   aerFields_t/aerSplit  : split of an AER word into destination and neuron id,
//                           kept here for routing logic that will consume it later
package spike_out_queue_pkg;

  localparam int DEFAULT_AER_BIT_WIDTH = 32;
  localparam int DEST_BIT_WIDTH        = 8;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  typedef struct packed {
    logic [DEST_BIT_WIDTH-1:0]                       dest;
    logic [DEFAULT_AER_BIT_WIDTH-DEST_BIT_WIDTH-1:0] neuronId;
  } aerFields_t;

  function automatic aerFields_t aerSplit(input logic [DEFAULT_AER_BIT_WIDTH-1:0] aer);
    return aerFields_t'(aer);
  endfunction

endpackage

// File: rtl/spike_fifo_mem.sv
// Packet storage for the spike output queue: DEPTH x WIDTH register file,
// one synchronous write port and one asynchronous read port.
//   clk    : write clock
//   wrEn   : write strobe
//   wrAddr : write index
//   wrData : packet to store
//   rdAddr : read index
//   rdData : packet at rdAddr (combinational)
// Contents are not reset; the parent only reads entries it has written.
module spike_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [PTR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [PTR_W-1:0] rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/spike_out_queue.sv
// Spike output queue between the neuron core and the NoC router injection port.
// Buffers fired-neuron AER packets in a FIFO, presents them first-word-fall-through
// with a valid/ready handshake, drops and counts packets on overflow so the neuron
// pipeline never stalls, and reports drain status to the time-step scheduler.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   outSpike_i        : spike strobe, one packet per high cycle
//   SpikeAER_i        : packet word sampled with outSpike_i
//   start_i           : time-step start pulse
//   clrStat_i         : synchronous clear of dropCnt_o / stepOvf_o
//   pktValid_o        : head packet valid toward the router
//   pktData_o         : head packet (0 when not valid)
//   pktReady_i        : router accepts head packet
//   drained_o         : queue empty and no push this cycle
//   stepOvf_o         : sticky drop flag
//   dropCnt_o         : saturating drop counter
//   late_o            : start_i seen while packets were still queued
module spike_out_queue
  import spike_out_queue_pkg::*;
#(
  parameter int AER_BIT_WIDTH      = DEFAULT_AER_BIT_WIDTH,
  parameter int FIFO_DEPTH         = 4,
  parameter int PTR_BIT_WIDTH      = 2,
  parameter int DROP_CNT_BIT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          outSpike_i,
  input  logic [AER_BIT_WIDTH-1:0]      SpikeAER_i,
  input  logic                          start_i,
  input  logic                          clrStat_i,
  output logic                          pktValid_o,
  output logic [AER_BIT_WIDTH-1:0]      pktData_o,
  input  logic                          pktReady_i,
  output logic                          drained_o,
  output logic                          stepOvf_o,
  output logic [DROP_CNT_BIT_WIDTH-1:0] dropCnt_o,
  output logic                          late_o
);

  localparam int CNT_W = PTR_BIT_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [PTR_BIT_WIDTH-1:0]      wp, rp;
  logic [CNT_W-1:0]              count, countNext;
  logic [0:0]                    state;
  logic                          full, empty;
  logic                          pop, pushAcc, drop;
  logic [AER_BIT_WIDTH-1:0]      rdData;
  logic [DROP_CNT_BIT_WIDTH-1:0] dropCnt;
  logic                          stepOvf, late;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Valid comes from the state register so it drops the instant rst_i rises.
  assign pktValid_o = (state == S_ACTIVE);
  assign pktData_o  = pktValid_o ? rdData : '0;
  assign drained_o  = empty & ~outSpike_i;

  assign pop     = pktValid_o & pktReady_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pushAcc = outSpike_i & (~full | pop);
  assign drop    = outSpike_i & full & ~pop;

  always_comb begin
    countNext = count;
    if (pushAcc && !pop)      countNext = count + 1'b1;
    else if (pop && !pushAcc) countNext = count - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      state <= S_IDLE;
    end else begin
      if (pushAcc) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      count <= countNext;
      // Deriving the next state from the next count keeps the FSM and the
      // occupancy in lockstep: IDLE->ACTIVE on an accepted push, back to IDLE
      // when the last packet leaves with no push alongside it.
      state <= (countNext != '0) ? S_ACTIVE : S_IDLE;
    end
  end

  // A drop in the same cycle as a clear is counted after the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dropCnt <= '0;
      stepOvf <= 1'b0;
    end else if (clrStat_i) begin
      dropCnt <= drop ? DROP_CNT_BIT_WIDTH'(1) : '0;
      stepOvf <= drop;
    end else if (drop) begin
      if (dropCnt != '1) dropCnt <= dropCnt + 1'b1;
      stepOvf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) late <= 1'b0;
    else       late <= start_i & ~empty;
  end

  assign dropCnt_o = dropCnt;
  assign stepOvf_o = stepOvf;
  assign late_o    = late;

  spike_fifo_mem #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(AER_BIT_WIDTH),
    .PTR_W(PTR_BIT_WIDTH)
  ) uMem (
    .clk   (clk_i),
    .wrEn  (pushAcc),
    .wrAddr(wp),
    .wrData(SpikeAER_i),
    .rdAddr(rp),
    .rdData(rdData)
  );

endmodule
